control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle LEGv8 control unit that sequences the datapath. Each cycle it decodes the current instruction against a registered 2-bit state and emits the 29-bit datapath control word and the K constant. It holds the registered status flags used by conditional branches. It stalls on memory handshakes and halts on undecodable opcodes.

## Interface
- No parameters; all encodings come from the shared package.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instruction  in  32  current instruction word, stable from the instruction fetch.
- status  in  4  live ALU flags {V,C,N,Z} for the current ALU result.
- mem_ready  in  1  data RAM completed the access this cycle.
- controlWord  out  29  {Psel[2], DA[5], SA[5], SB[5], Fsel[5], regW, ramW, Dsel[2], Bsel, PCsel, SL}.
- K  out  64  constant to the datapath B mux and PC adder.
- state  out  2  registered state.
- status_q  out  4  registered flags {V,C,N,Z}.
- halted  out  1  high while state is HALT.

## Operation
- Psel encodings:
  - 00: hold PC.
  - 01: PC+4.
  - 10: PC+K*4.
  - 11: PC from the A bus (PCsel=1).
- Dsel encodings: 00 RAM, 01 ALU, 10 PC+4, 11 K.
- Fsel encodings: AND 00000, ORR 00100, ADD 01000, EOR 01100, SUB 01001, PASS_B 10100.
- States: EXEC=00, MEM=01, LINK=10, HALT=11.
- Single-cycle in EXEC, next state EXEC, Psel=01 unless noted:
  - ADD/SUB/AND/ORR/EOR reg: DA=Rd, SA=Rn, SB=Rm, regW=1, Dsel=01, Bsel=0.
  - ADDI/SUBI: K=zext(imm12), Bsel=1.
  - ADDS/SUBS: same as the reg forms with SL=1.
  - MOVZ: K=zext(imm16)<<(16*hw), Dsel=11, regW=1.
  - BR: SA=Rn, Psel=11, PCsel=1, no writes.
  - B: K=sext(imm26), Psel=10.
  - CBZ/CBNZ: SA=31, SB=Rt, Fsel=PASS_B. Branch taken when live status.Z is 1 (CBZ) or 0 (CBNZ). Taken gives Psel=10 with K=sext(imm19); not taken gives Psel=01.
  - B.cond: evaluated on status_q with the standard codes 0–15; 14 and 15 are always taken. K=sext(imm19).
- LDUR/STUR:
  - EXEC: SA=Rn, K=sext(imm9), Bsel=1, Fsel=ADD, Psel=00; go to MEM.
  - MEM: same address fields. STUR drives ramW=1 and SB=Rt. LDUR drives Dsel=00 and DA=Rt.
  - mem_ready=0: Psel=00, regW=0; stay in MEM.
  - mem_ready=1: Psel=01; LDUR also drives regW=1; go to EXEC.
- BL:
  - EXEC: DA=30, Dsel=10, regW=1, Psel=00; go to LINK.
  - LINK: K=sext(imm26), Psel=10, no writes; go to EXEC.
- Any other opcode in EXEC goes to HALT. HALT is sticky until reset, with all write enables 0 and Psel=00.
- status_q loads status on a clock edge only when state=EXEC and SL=1.

## Timing
- Reset values: state=EXEC, status_q=0000, halted=0.
- controlWord and K are combinational from instruction and the current state; K=0 when unused.
- Latencies:
  - ALU ops, B, BR, CB, B.cond: 1 cycle.
  - BL: 2 cycles.
  - LDUR/STUR: 2 cycles plus one cycle per cycle that mem_ready is low.
- mem_ready is ignored outside MEM.
- If reset asserts during MEM, the state goes to EXEC immediately and ramW deasserts asynchronously.
- Outside HALT, regW and ramW are never high together.

## Structure
- Package control_pkg holds:
  - opcode match constants;
  - state encodings;
  - Psel, Dsel and Fsel constants;
  - condition codes;
  - control-word field offsets.
- Sub-module cond_eval is purely combinational. It takes status_q[3:0] and cond[3:0] and produces taken.
- control_unit holds the state register, status_q and the opcode decode.

## Test plan
- Reset mid-STUR with mem_ready=0 held for 3 cycles → state=00, ramW=0, status_q=0000 immediately.
- ADDS X1,X2,X3 with status=0001 → controlWord has SL=1, regW=1, Psel=01; the next cycle status_q=0001. A following B.EQ with imm19=4 gives Psel=10 and K=4.
- LDUR X5,[X6,#-8] with mem_ready low for 2 cycles → K=0xFFFF_FFFF_FFFF_FFF8; state sequence 00,01,01,01,00; regW=1 only in the final MEM cycle.
- BL imm26=0x3FFFFFF → cycle 1: DA=30, Dsel=10, regW=1, Psel=00. Cycle 2: state=10, K=-1, Psel=10. Cycle 3: state=00.
- CBNZ X9 with status.Z=1, then Z=0 → Psel=01, then Psel=10.
- Instruction 0x00000000 → state=11, halted=1, all write enables 0, Psel=00 for 5 cycles; reset returns state to 00.

Source files
------------

// File: rtl/control_pkg.sv
// control_pkg: shared encodings for the LEGv8 multi-cycle control unit
package control_pkg;
  typedef enum logic [1:0] {ST_EXEC = 2'b00, ST_MEM = 2'b01, ST_LINK = 2'b10, ST_HALT = 2'b11} state_t;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_BR   = 11'b11010110000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [5:0]  OP_BL   = 6'b100101;
  localparam logic [1:0] PSEL_HOLD = 2'b00;
  localparam logic [1:0] PSEL_INC  = 2'b01;
  localparam logic [1:0] PSEL_BR   = 2'b10;
  localparam logic [1:0] PSEL_REG  = 2'b11;
  localparam logic [1:0] DSEL_RAM = 2'b00;
  localparam logic [1:0] DSEL_ALU = 2'b01;
  localparam logic [1:0] DSEL_PC4 = 2'b10;
  localparam logic [1:0] DSEL_K   = 2'b11;
  localparam logic [4:0] FSEL_AND   = 5'b00000;
  localparam logic [4:0] FSEL_ORR   = 5'b00100;
  localparam logic [4:0] FSEL_ADD   = 5'b01000;
  localparam logic [4:0] FSEL_EOR   = 5'b01100;
  localparam logic [4:0] FSEL_SUB   = 5'b01001;
  localparam logic [4:0] FSEL_PASSB = 5'b10100;
  // Even condition codes; the odd code of each pair is the inverse (except AL).
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_HS = 4'd2;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam int CW_W     = 29;
  localparam int CW_PSEL  = 27;
  localparam int CW_DA    = 22;
  localparam int CW_SA    = 17;
  localparam int CW_SB    = 12;
  localparam int CW_FSEL  = 7;
  localparam int CW_REGW  = 6;
  localparam int CW_RAMW  = 5;
  localparam int CW_DSEL  = 3;
  localparam int CW_BSEL  = 2;
  localparam int CW_PCSEL = 1;
  localparam int CW_SL    = 0;
  function automatic logic [4:0] r_fsel(input logic [10:0] op);
    return (op == OP_ADD || op == OP_ADDS) ? FSEL_ADD :
           (op == OP_SUB || op == OP_SUBS) ? FSEL_SUB :
           (op == OP_ORR) ? FSEL_ORR :
           (op == OP_EOR) ? FSEL_EOR : FSEL_AND;
  endfunction
endpackage

// File: rtl/control_unit_cond_eval.sv
// cond_eval: evaluates a B.cond condition code against the registered flags
module cond_eval
  import control_pkg::*;
(
  input  logic [3:0] status_i,
  input  logic [3:0] cond_i,
  output logic       taken_o
);
  logic v, c, n, z, base;
  logic [3:0] pair;
  assign {v, c, n, z} = status_i;
  assign pair = {cond_i[3:1], 1'b0};
  // Evaluate the even code of the pair, then invert for the odd code; AL/NV always taken
  always_comb begin
    base = (pair == COND_EQ) ? z :
           (pair == COND_HS) ? c :
           (pair == COND_MI) ? n :
           (pair == COND_VS) ? v :
           (pair == COND_HI) ? (c & ~z) :
           (pair == COND_GE) ? (n == v) :
           (pair == COND_GT) ? (~z & (n == v)) : 1'b1;
    taken_o = (pair == COND_AL) ? 1'b1 : base ^ cond_i[0];
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle LEGv8 sequencer producing the datapath control word and K
module control_unit
  import control_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [3:0]  status,
  input  logic        mem_ready,
  output logic [28:0] controlWord,
  output logic [63:0] K,
  output logic [1:0]  state,
  output logic [3:0]  status_q,
  output logic        halted
);
  state_t state_q, state_d;
  logic [1:0] psel, dsel;
  logic [4:0] da, sa, sb, fsel;
  logic regw, ramw, bsel, pcsel, sl, taken;
  logic [10:0] op11;
  logic [4:0] rd, rn, rm;
  logic [63:0] k_imm9, k_imm12, k_imm19, k_imm26, k_movz;
  assign op11 = instruction[31:21];
  assign rd = instruction[4:0];
  assign rn = instruction[9:5];
  assign rm = instruction[20:16];
  assign k_imm9 = {{55{instruction[20]}}, instruction[20:12]};
  assign k_imm12 = {52'b0, instruction[21:10]};
  assign k_imm19 = {{45{instruction[23]}}, instruction[23:5]};
  assign k_imm26 = {{38{instruction[25]}}, instruction[25:0]};
  assign k_movz = {48'b0, instruction[20:5]} << {instruction[22:21], 4'b0000};
  assign state = state_q;
  assign halted = (state_q == ST_HALT);
  cond_eval u_cond (.status_i(status_q), .cond_i(instruction[3:0]), .taken_o(taken));
  // Decode the instruction against the current state into control fields and next state
  always_comb begin
    psel = PSEL_HOLD;
    da = '0;
    sa = '0;
    sb = '0;
    fsel = FSEL_AND;
    regw = 1'b0;
    ramw = 1'b0;
    dsel = DSEL_RAM;
    bsel = 1'b0;
    pcsel = 1'b0;
    sl = 1'b0;
    K = '0;
    state_d = state_q;
    case (state_q)
      ST_EXEC: begin
        psel = PSEL_INC;
        if (op11 == OP_ADD || op11 == OP_SUB || op11 == OP_AND || op11 == OP_ORR ||
            op11 == OP_EOR || op11 == OP_ADDS || op11 == OP_SUBS) begin
          da = rd;
          sa = rn;
          sb = rm;
          regw = 1'b1;
          dsel = DSEL_ALU;
          fsel = r_fsel(op11);
          sl = (op11 == OP_ADDS) || (op11 == OP_SUBS);
        end else if (instruction[31:22] == OP_ADDI || instruction[31:22] == OP_SUBI) begin
          da = rd;
          sa = rn;
          K = k_imm12;
          bsel = 1'b1;
          regw = 1'b1;
          dsel = DSEL_ALU;
          fsel = (instruction[31:22] == OP_ADDI) ? FSEL_ADD : FSEL_SUB;
        end else if (instruction[31:23] == OP_MOVZ) begin
          da = rd;
          K = k_movz;
          dsel = DSEL_K;
          regw = 1'b1;
        end else if (op11 == OP_BR) begin
          sa = rn;
          psel = PSEL_REG;
          pcsel = 1'b1;
        end else if (instruction[31:26] == OP_B) begin
          K = k_imm26;
          psel = PSEL_BR;
        end else if (instruction[31:24] == OP_CBZ || instruction[31:24] == OP_CBNZ) begin
          sa = 5'd31;
          sb = rd;
          fsel = FSEL_PASSB;
          psel = (status[0] ^ instruction[24]) ? PSEL_BR : PSEL_INC;
          K = (status[0] ^ instruction[24]) ? k_imm19 : '0;
        end else if (instruction[31:24] == OP_BCOND) begin
          K = k_imm19;
          psel = taken ? PSEL_BR : PSEL_INC;
        end else if (op11 == OP_LDUR || op11 == OP_STUR) begin
          sa = rn;
          K = k_imm9;
          bsel = 1'b1;
          fsel = FSEL_ADD;
          psel = PSEL_HOLD;
          state_d = ST_MEM;
        end else if (instruction[31:26] == OP_BL) begin
          da = 5'd30;
          dsel = DSEL_PC4;
          regw = 1'b1;
          psel = PSEL_HOLD;
          state_d = ST_LINK;
        end else begin
          psel = PSEL_HOLD;
          state_d = ST_HALT;
        end
      end
      ST_MEM: begin
        sa = rn;
        K = k_imm9;
        bsel = 1'b1;
        fsel = FSEL_ADD;
        psel = mem_ready ? PSEL_INC : PSEL_HOLD;
        state_d = mem_ready ? ST_EXEC : ST_MEM;
        ramw = (op11 == OP_STUR);
        sb = (op11 == OP_STUR) ? rd : 5'd0;
        da = (op11 == OP_STUR) ? 5'd0 : rd;
        regw = (op11 != OP_STUR) && mem_ready;
      end
      ST_LINK: begin
        K = k_imm26;
        psel = PSEL_BR;
        state_d = ST_EXEC;
      end
      default: state_d = ST_HALT;
    endcase
  end
  // Pack the control fields at their word offsets
  always_comb begin
    controlWord = '0;
    controlWord[CW_PSEL +: 2] = psel;
    controlWord[CW_DA +: 5] = da;
    controlWord[CW_SA +: 5] = sa;
    controlWord[CW_SB +: 5] = sb;
    controlWord[CW_FSEL +: 5] = fsel;
    controlWord[CW_REGW] = regw;
    controlWord[CW_RAMW] = ramw;
    controlWord[CW_DSEL +: 2] = dsel;
    controlWord[CW_BSEL] = bsel;
    controlWord[CW_PCSEL] = pcsel;
    controlWord[CW_SL] = sl;
  end
  // State register and flag capture for flag-setting ALU ops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_EXEC;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_EXEC && sl) status_q <= status;
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed scoreboard bench for the LEGv8 control unit
module tb_control_unit;
  logic clock = 1'b0;
  logic reset, mem_ready;
  logic [31:0] instruction;
  logic [3:0] status, status_q;
  logic [28:0] controlWord;
  logic [63:0] K;
  logic [1:0] state;
  logic halted;
  logic [1:0] psel, dsel;
  logic [4:0] da, sa, sb, fsel;
  logic regw, ramw, bsel, pcsel, sl;
  typedef struct {
    string tag;
    logic [63:0] exp;
  } exp_t;
  exp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;
  localparam logic [31:0] I_ADDS  = {11'b10101011000, 5'd3, 6'd0, 5'd2, 5'd1};
  localparam logic [31:0] I_ADD   = {11'b10001011000, 5'd3, 6'd0, 5'd2, 5'd1};
  localparam logic [31:0] I_BEQ   = {8'b01010100, 19'd4, 1'b0, 4'd0};
  localparam logic [31:0] I_BNE   = {8'b01010100, 19'd4, 1'b0, 4'd1};
  localparam logic [31:0] I_BAL   = {8'b01010100, 19'h7FFFE, 1'b0, 4'd14};
  localparam logic [31:0] I_STUR  = {11'b11111000000, 9'd16, 2'b00, 5'd6, 5'd7};
  localparam logic [31:0] I_LDUR  = {11'b11111000010, 9'h1F8, 2'b00, 5'd6, 5'd5};
  localparam logic [31:0] I_BL    = {6'b100101, 26'h3FFFFFF};
  localparam logic [31:0] I_CBNZ  = {8'b10110101, 19'd3, 5'd9};
  localparam logic [31:0] I_CBZ   = {8'b10110100, 19'd5, 5'd9};
  localparam logic [31:0] I_MOVZ  = {9'b110100101, 2'd2, 16'hBEEF, 5'd4};
  localparam logic [31:0] I_ADDI  = {10'b1001000100, 12'hFFF, 5'd2, 5'd1};
  localparam logic [31:0] I_SUBI  = {10'b1101000100, 12'd1, 5'd3, 5'd3};
  localparam logic [31:0] I_BR    = {11'b11010110000, 5'b11111, 6'd0, 5'd30, 5'd0};
  control_unit dut (
    .clock(clock), .reset(reset), .instruction(instruction), .status(status),
    .mem_ready(mem_ready), .controlWord(controlWord), .K(K), .state(state),
    .status_q(status_q), .halted(halted)
  );
  assign {psel, da, sa, sb, fsel, regw, ramw, dsel, bsel, pcsel, sl} = controlWord;
  always #5 clock = ~clock;
  task automatic push(input string tag, input logic [63:0] e);
    sb_q.push_back('{tag, e});
  endtask
  task automatic check(input logic [63:0] obs);
    exp_t x;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed %h", obs);
    end else begin
      x = sb_q.pop_front();
      assert (obs === x.exp) else begin
        miscompares++;
        $error("FAIL %s observed %h expected %h", x.tag, obs, x.exp);
      end
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    instruction = I_STUR;
    status = 4'b0000;
    mem_ready = 1'b0;
    #2;
    push("rst_state", 0); push("rst_status_q", 0); push("rst_halted", 0);
    check(state); check(status_q); check(halted);
    step();
    reset = 1'b0;
    instruction = I_ADDS;
    status = 4'b0001;
    push("adds_sl", 1); push("adds_regw", 1); push("adds_psel", 1); push("adds_da", 1);
    push("adds_sa", 2); push("adds_sb", 3); push("adds_fsel", 5'b01000); push("adds_dsel", 1);
    #2;
    check(sl); check(regw); check(psel); check(da); check(sa); check(sb); check(fsel); check(dsel);
    step();
    instruction = I_BEQ;
    status = 4'b0000;
    push("adds_status_q", 4'b0001); push("beq_psel", 2); push("beq_k", 4);
    #2;
    check(status_q); check(psel); check(K);
    step();
    instruction = I_BNE;
    push("bne_state", 0); push("bne_psel", 1);
    #2;
    check(state); check(psel);
    step();
    instruction = I_BAL;
    push("bal_psel", 2); push("bal_k", 64'hFFFF_FFFF_FFFF_FFFE);
    #2;
    check(psel); check(K);
    step();
    instruction = I_ADD;
    status = 4'b1111;
    push("add_sl", 0); push("add_regw", 1); push("add_k", 0);
    #2;
    check(sl); check(regw); check(K);
    step();
    instruction = I_STUR;
    mem_ready = 1'b0;
    push("add_keeps_status_q", 4'b0001); push("stur_exec_state", 0); push("stur_exec_ramw", 0);
    push("stur_exec_psel", 0); push("stur_exec_k", 16);
    #2;
    check(status_q); check(state); check(ramw); check(psel); check(K);
    for (int i = 0; i < 3; i++) begin
      step();
      push("stur_wait_state", 1); push("stur_wait_ramw", 1); push("stur_wait_regw", 0);
      push("stur_wait_psel", 0); push("stur_wait_sb", 7);
      #2;
      check(state); check(ramw); check(regw); check(psel); check(sb);
    end
    reset = 1'b1;
    #1;
    push("async_rst_state", 0); push("async_rst_ramw", 0); push("async_rst_status_q", 0);
    check(state); check(ramw); check(status_q);
    step();
    reset = 1'b0;
    instruction = I_LDUR;
    mem_ready = 1'b1;
    push("ldur_exec_state", 0); push("ldur_k", 64'hFFFF_FFFF_FFFF_FFF8); push("ldur_exec_psel", 0);
    push("ldur_exec_regw", 0); push("ldur_exec_bsel", 1); push("ldur_exec_fsel", 5'b01000);
    push("ldur_exec_sa", 6);
    #2;
    check(state); check(K); check(psel); check(regw); check(bsel); check(fsel); check(sa);
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push("ldur_wait_state", 1); push("ldur_wait_regw", 0); push("ldur_wait_psel", 0);
      push("ldur_wait_ramw", 0);
      #2;
      check(state); check(regw); check(psel); check(ramw);
      step();
    end
    mem_ready = 1'b1;
    push("ldur_done_state", 1); push("ldur_done_regw", 1); push("ldur_done_da", 5);
    push("ldur_done_dsel", 0); push("ldur_done_psel", 1); push("ldur_done_ramw", 0);
    #2;
    check(state); check(regw); check(da); check(dsel); check(psel); check(ramw);
    step();
    mem_ready = 1'b0;
    instruction = I_BL;
    push("bl1_state", 0); push("bl1_da", 30); push("bl1_dsel", 2); push("bl1_regw", 1);
    push("bl1_psel", 0); push("bl1_k", 0);
    #2;
    check(state); check(da); check(dsel); check(regw); check(psel); check(K);
    step();
    mem_ready = 1'b1;
    push("bl2_state", 2); push("bl2_k", 64'hFFFF_FFFF_FFFF_FFFF); push("bl2_psel", 2);
    push("bl2_regw", 0);
    #2;
    check(state); check(K); check(psel); check(regw);
    step();
    instruction = I_CBNZ;
    status = 4'b0001;
    push("bl3_state", 0); push("cbnz_z1_psel", 1); push("cbnz_sa", 31); push("cbnz_sb", 9);
    push("cbnz_fsel", 5'b10100);
    #2;
    check(state); check(psel); check(sa); check(sb); check(fsel);
    step();
    status = 4'b0000;
    push("cbnz_z0_psel", 2); push("cbnz_z0_k", 3);
    #2;
    check(psel); check(K);
    step();
    instruction = I_CBZ;
    status = 4'b0001;
    push("cbz_z1_psel", 2); push("cbz_z1_k", 5);
    #2;
    check(psel); check(K);
    step();
    instruction = I_MOVZ;
    status = 4'b0000;
    push("movz_k", 64'h0000_BEEF_0000_0000); push("movz_dsel", 3); push("movz_regw", 1);
    push("movz_da", 4);
    #2;
    check(K); check(dsel); check(regw); check(da);
    step();
    instruction = I_ADDI;
    push("addi_k", 64'hFFF); push("addi_bsel", 1); push("addi_fsel", 5'b01000); push("addi_dsel", 1);
    #2;
    check(K); check(bsel); check(fsel); check(dsel);
    step();
    instruction = I_SUBI;
    push("subi_fsel", 5'b01001); push("subi_k", 1);
    #2;
    check(fsel); check(K);
    step();
    instruction = I_BR;
    push("br_psel", 3); push("br_pcsel", 1); push("br_sa", 30); push("br_regw", 0);
    #2;
    check(psel); check(pcsel); check(sa); check(regw);
    step();
    instruction = 32'h0000_0000;
    push("bad_state", 0); push("bad_psel", 0); push("bad_regw", 0);
    #2;
    check(state); check(psel); check(regw);
    for (int i = 0; i < 5; i++) begin
      step();
      instruction = I_ADD;
      push("halt_state", 3); push("halt_halted", 1); push("halt_regw", 0); push("halt_ramw", 0);
      push("halt_psel", 0);
      #2;
      check(state); check(halted); check(regw); check(ramw); check(psel);
    end
    reset = 1'b1;
    #1;
    push("halt_rst_state", 0); push("halt_rst_halted", 0);
    check(state); check(halted);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
